// File: rtl/fetch_stage_du_pkg.sv
// Shared constants and state encoding for the debug-controlled fetch stage.
package fetch_stage_du_pkg;

    localparam int NB_BITS         = 32;
    localparam int NB_JUMP         = 26;
    localparam int RAM_FETCH_DEPTH = 10;
    localparam int NB_CNT          = 16;

    localparam logic [31:0] NOP_OPERATION = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FETCH_ST_LOAD = 2'b00,
        FETCH_ST_RUN  = 2'b01,
        FETCH_ST_HALT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_du_instr_ram_sp.sv
// Single-port instruction RAM: synchronous write, read register loads only on read enable.
module instr_ram_sp #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_rd_data
);

    logic [NB_DATA-1:0] mem_r [0:(2**NB_ADDR)-1];
    logic [NB_DATA-1:0] rd_data_r;

    // Memory array write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_addr] <= i_wr_data;
        end
    end

    // Registered read, held while the pipeline is stalled
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            rd_data_r <= mem_r[i_addr];
        end
    end

    assign o_rd_data = rd_data_r;

endmodule

// File: rtl/fetch_stage_du.sv
// MIPS IF stage with PC, next-PC mux, IF/ID register and a debug-unit run/step/halt FSM.
module fetch_stage_du #(
    parameter int                       NB_BITS    = fetch_stage_du_pkg::NB_BITS,
    parameter int                       NB_JMP     = fetch_stage_du_pkg::NB_JUMP,
    parameter int                       RAM_DEPTH  = fetch_stage_du_pkg::RAM_FETCH_DEPTH,
    parameter int                       NB_CNT     = fetch_stage_du_pkg::NB_CNT,
    parameter logic [NB_BITS-1:0]       NOP_INSTR  = fetch_stage_du_pkg::NOP_OPERATION,
    parameter logic [NB_BITS-1:0]       HALT_INSTR = fetch_stage_du_pkg::HALT_INSTR
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_BITS-1:0]   i_brq_addr,
    input  logic [NB_JMP-1:0]    i_jmp_addr,
    input  logic                 i_ctr_beq,
    input  logic                 i_ctr_jmp,
    input  logic                 i_ctr_flush,
    input  logic                 i_pc_we,
    input  logic                 i_if_id_we,
    input  logic                 i_du_wr_en,
    input  logic [RAM_DEPTH-1:0] i_du_wr_addr,
    input  logic [NB_BITS-1:0]   i_du_wr_data,
    input  logic                 i_du_start,
    input  logic                 i_du_step_mode,
    input  logic                 i_du_step,
    input  logic                 i_du_reload,
    output logic [NB_BITS-1:0]   o_if_id_pc,
    output logic [NB_BITS-1:0]   o_if_id_instr,
    output logic [1:0]           o_state,
    output logic                 o_halt,
    output logic [NB_CNT-1:0]    o_fetch_cnt
);

    import fetch_stage_du_pkg::*;

    localparam logic [NB_BITS-1:0] PC_INC  = NB_BITS'(3'd4);
    localparam logic [NB_BITS-1:0] PC_ZERO = {NB_BITS{1'b0}};
    localparam logic [NB_CNT-1:0]  CNT_MAX = {NB_CNT{1'b1}};

    fetch_state_e           state_r;
    fetch_state_e           state_next_s;
    logic [NB_BITS-1:0]     pc_r;
    logic [NB_BITS-1:0]     if_id_pc_r;
    logic                   flush_q_r;
    logic [NB_CNT-1:0]      fetch_cnt_r;

    logic [NB_BITS-1:0]     pc_plus4_s;
    logic [NB_BITS-1:0]     next_pc_s;
    logic [NB_BITS-1:0]     ram_rd_s;
    logic [RAM_DEPTH-1:0]   ram_addr_s;
    logic                   ram_we_s;
    logic                   load_s;
    logic                   run_s;
    logic                   start_s;
    logic                   halt_det_s;
    logic                   adv_s;
    logic                   pc_adv_s;
    logic                   ifid_adv_s;

    assign pc_plus4_s = pc_r + PC_INC;

    // Control decode; a visible HALT blocks further advance so PC and count stay on it
    always_comb begin
        load_s     = (state_r == FETCH_ST_LOAD);
        run_s      = (state_r == FETCH_ST_RUN);
        start_s    = load_s & i_du_start;
        halt_det_s = run_s & ~flush_q_r & (ram_rd_s == HALT_INSTR);
        adv_s      = run_s & ~halt_det_s & (~i_du_step_mode | i_du_step);
        pc_adv_s   = adv_s & i_pc_we;
        ifid_adv_s = adv_s & i_if_id_we;
        ram_we_s   = load_s & i_du_wr_en;
    end

    // RAM port owner: debug loader in LOAD, PC otherwise
    always_comb begin
        ram_addr_s = pc_r[RAM_DEPTH+1:2];
        if (load_s) begin
            ram_addr_s = i_du_wr_addr;
        end else begin
            ram_addr_s = pc_r[RAM_DEPTH+1:2];
        end
    end

    // Next-PC selection, jump wins over branch
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (i_ctr_jmp) begin
            next_pc_s = {if_id_pc_r[NB_BITS-1:NB_JMP], i_jmp_addr};
        end else if (i_ctr_beq) begin
            next_pc_s = i_brq_addr;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    instr_ram_sp #(
        .NB_DATA (NB_BITS),
        .NB_ADDR (RAM_DEPTH)
    ) u_instr_ram (
        .i_clk     (i_clk),
        .i_we      (ram_we_s),
        .i_re      (ifid_adv_s),
        .i_addr    (ram_addr_s),
        .i_wr_data (i_du_wr_data),
        .o_rd_data (ram_rd_s)
    );

    // Debug FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH_ST_LOAD: begin
                if (i_du_start) state_next_s = FETCH_ST_RUN;
                else            state_next_s = FETCH_ST_LOAD;
            end
            FETCH_ST_RUN: begin
                if (halt_det_s) state_next_s = FETCH_ST_HALT;
                else            state_next_s = FETCH_ST_RUN;
            end
            FETCH_ST_HALT: begin
                if (i_du_reload) state_next_s = FETCH_ST_LOAD;
                else             state_next_s = FETCH_ST_HALT;
            end
            default: state_next_s = FETCH_ST_LOAD;
        endcase
    end

    // Debug FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= FETCH_ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC, IF/ID register and fetch counter; start re-initialises them like reset
    always_ff @(posedge i_clk) begin
        if (i_rst || start_s) begin
            pc_r        <= PC_ZERO;
            if_id_pc_r  <= PC_ZERO;
            flush_q_r   <= 1'b1;
            fetch_cnt_r <= {NB_CNT{1'b0}};
        end else begin
            if (pc_adv_s) begin
                pc_r <= next_pc_s;
            end
            if (ifid_adv_s) begin
                if_id_pc_r <= pc_plus4_s;
                flush_q_r  <= i_ctr_flush;
                if (fetch_cnt_r != CNT_MAX) begin
                    fetch_cnt_r <= fetch_cnt_r + NB_CNT'(1'b1);
                end
            end
        end
    end

    assign o_if_id_instr = (flush_q_r || !run_s) ? NOP_INSTR : ram_rd_s;
    assign o_if_id_pc    = if_id_pc_r;
    assign o_state       = state_r;
    assign o_halt        = (state_r == FETCH_ST_HALT);
    assign o_fetch_cnt   = fetch_cnt_r;

endmodule

// File: tb/tb_fetch_stage_du.sv
// Directed testbench for fetch_stage_du: load, run, branch/jump, stall, flush, step, halt, reload, reset.
module tb_fetch_stage_du;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_brq_addr;
    logic [25:0] i_jmp_addr;
    logic        i_ctr_beq;
    logic        i_ctr_jmp;
    logic        i_ctr_flush;
    logic        i_pc_we;
    logic        i_if_id_we;
    logic        i_du_wr_en;
    logic [9:0]  i_du_wr_addr;
    logic [31:0] i_du_wr_data;
    logic        i_du_start;
    logic        i_du_step_mode;
    logic        i_du_step;
    logic        i_du_reload;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_instr;
    logic [1:0]  o_state;
    logic        o_halt;
    logic [15:0] o_fetch_cnt;

    int n_checks;
    int n_errors;

    fetch_stage_du dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_brq_addr     (i_brq_addr),
        .i_jmp_addr     (i_jmp_addr),
        .i_ctr_beq      (i_ctr_beq),
        .i_ctr_jmp      (i_ctr_jmp),
        .i_ctr_flush    (i_ctr_flush),
        .i_pc_we        (i_pc_we),
        .i_if_id_we     (i_if_id_we),
        .i_du_wr_en     (i_du_wr_en),
        .i_du_wr_addr   (i_du_wr_addr),
        .i_du_wr_data   (i_du_wr_data),
        .i_du_start     (i_du_start),
        .i_du_step_mode (i_du_step_mode),
        .i_du_step      (i_du_step),
        .i_du_reload    (i_du_reload),
        .o_if_id_pc     (o_if_id_pc),
        .o_if_id_instr  (o_if_id_instr),
        .o_state        (o_state),
        .o_halt         (o_halt),
        .o_fetch_cnt    (o_fetch_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] cnt);
        check_eq({tag, "_instr"}, o_if_id_instr, instr);
        check_eq({tag, "_pc"}, o_if_id_pc, pc);
        check_eq({tag, "_cnt"}, 32'(o_fetch_cnt), cnt);
    endtask

    // Second program image: byte-replicated word index, word 0 = 0, word 18 = HALT
    function automatic logic [31:0] prog2(input int n);
        logic [7:0] b;
        b = n[7:0];
        if (n == 0)       return 32'h0000_0000;
        else if (n == 18) return HALT_W;
        else              return {4{b}};
    endfunction

    task automatic load_word(input int addr, input logic [31:0] data);
        i_du_wr_en   = 1'b1;
        i_du_wr_addr = addr[9:0];
        i_du_wr_data = data;
        tick();
        i_du_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        i_du_start = 1'b1;
        tick();
        i_du_start = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        i_rst          = 1'b1;
        i_brq_addr     = 32'h0;
        i_jmp_addr     = 26'h0;
        i_ctr_beq      = 1'b0;
        i_ctr_jmp      = 1'b0;
        i_ctr_flush    = 1'b0;
        i_pc_we        = 1'b1;
        i_if_id_we     = 1'b1;
        i_du_wr_en     = 1'b0;
        i_du_wr_addr   = 10'h0;
        i_du_wr_data   = 32'h0;
        i_du_start     = 1'b0;
        i_du_step_mode = 1'b0;
        i_du_step      = 1'b0;
        i_du_reload    = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        check_eq("rst_state", 32'(o_state), 32'd0);
        check_eq("rst_halt", 32'(o_halt), 32'd0);
        check_if("rst", 32'h0, 32'h0, 32'd0);

        // Program 1: two addi then HALT
        load_word(0, 32'h2008_0005);
        load_word(1, 32'h2009_0003);
        load_word(2, HALT_W);
        pulse_start();
        check_eq("start_state", 32'(o_state), 32'd1);
        check_if("start", 32'h0, 32'h0, 32'd0);
        tick();
        check_if("p1_w0", 32'h2008_0005, 32'h4, 32'd1);
        tick();
        check_if("p1_w1", 32'h2009_0003, 32'h8, 32'd2);
        tick();
        check_if("p1_halt_vis", HALT_W, 32'hC, 32'd3);
        check_eq("p1_halt_pre", 32'(o_halt), 32'd0);
        tick();
        check_eq("p1_halt_state", 32'(o_state), 32'd2);
        check_eq("p1_halt", 32'(o_halt), 32'd1);
        check_if("p1_halted", 32'h0, 32'hC, 32'd3);
        pulse_start();
        check_eq("start_in_halt", 32'(o_state), 32'd2);
        check_if("halt_frozen", 32'h0, 32'hC, 32'd3);

        // Reload and program 2
        i_du_reload = 1'b1;
        tick();
        i_du_reload = 1'b0;
        check_eq("reload_state", 32'(o_state), 32'd0);
        check_eq("reload_halt", 32'(o_halt), 32'd0);
        for (int i = 0; i < 25; i++) load_word(i, prog2(i));
        pulse_start();
        check_if("p2_start", 32'h0, 32'h0, 32'd0);
        tick();
        check_if("p2_w0", prog2(0), 32'h4, 32'd1);
        check_eq("p2_state", 32'(o_state), 32'd1);

        // Branch to a high address aliasing word 3
        i_ctr_beq  = 1'b1;
        i_brq_addr = 32'h0040_000C;
        tick();
        i_ctr_beq  = 1'b0;
        check_if("beq_slot", prog2(1), 32'h8, 32'd2);
        tick();
        check_if("beq_tgt", prog2(3), 32'h0040_0010, 32'd3);

        // Jump with simultaneous branch: jump must win
        i_ctr_jmp  = 1'b1;
        i_jmp_addr = 26'h000_0040;
        i_ctr_beq  = 1'b1;
        i_brq_addr = 32'h0000_0100;
        tick();
        i_ctr_jmp  = 1'b0;
        i_ctr_beq  = 1'b0;
        check_if("jmp_slot", prog2(4), 32'h0040_0014, 32'd4);
        tick();
        check_if("jmp_tgt", prog2(16), 32'h44, 32'd5);

        // Hazard stall
        i_pc_we    = 1'b0;
        i_if_id_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_if("stall", prog2(16), 32'h44, 32'd5);
        end
        i_pc_we    = 1'b1;
        i_if_id_we = 1'b1;
        tick();
        check_if("post_stall", prog2(17), 32'h48, 32'd6);

        // Flush over the HALT word at word 18
        i_ctr_flush = 1'b1;
        tick();
        i_ctr_flush = 1'b0;
        check_if("flush", 32'h0, 32'h4C, 32'd7);
        tick();
        check_if("post_flush", prog2(19), 32'h50, 32'd8);
        check_eq("flushed_halt_state", 32'(o_state), 32'd1);
        check_eq("flushed_halt_flag", 32'(o_halt), 32'd0);

        // Write attempt while running must not touch memory
        i_du_wr_en   = 1'b1;
        i_du_wr_addr = 10'd21;
        i_du_wr_data = 32'hDEAD_BEEF;
        tick();
        i_du_wr_en   = 1'b0;
        check_if("run_wr", prog2(20), 32'h54, 32'd9);

        // Single-step mode
        i_du_step_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_if("step_idle", prog2(20), 32'h54, 32'd9);
        end
        i_du_step = 1'b1;
        tick();
        i_du_step = 1'b0;
        check_if("step1", prog2(21), 32'h58, 32'd10);
        tick();
        check_if("step_hold", prog2(21), 32'h58, 32'd10);
        i_du_step = 1'b1;
        tick();
        tick();
        i_du_step = 1'b0;
        check_if("step2", prog2(23), 32'h60, 32'd12);
        i_du_step_mode = 1'b0;

        // Branch back and re-fetch word 20 to confirm it was not overwritten
        i_ctr_beq  = 1'b1;
        i_brq_addr = 32'h0000_0050;
        tick();
        i_ctr_beq  = 1'b0;
        check_if("back_slot", prog2(24), 32'h64, 32'd13);
        tick();
        check_if("refetch_w20", prog2(20), 32'h54, 32'd14);

        // Synchronous reset mid-run; memory image survives
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_eq("midrst_state", 32'(o_state), 32'd0);
        check_eq("midrst_halt", 32'(o_halt), 32'd0);
        check_if("midrst", 32'h0, 32'h0, 32'd0);
        pulse_start();
        tick();
        tick();
        check_if("after_rst_w1", prog2(1), 32'h8, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
